fp16_sub_seq: RTL and testbench



---
 rtl/fp16_pkg.sv | 28 ++
 rtl/fp16_classify.sv | 21 ++
 rtl/fp16_sub_seq.sv | 181 ++++++++++++++++++
 tb/tb_fp16_sub_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the subtractor and its companion adder.
// Format: 1 sign, 5 exponent, 10 fraction bits, hidden leading 1.
package fp16_pkg;

   localparam int FP16_W = 16;
   localparam int EXP_W  = 5;
   localparam int FRAC_W = 10;
   localparam int MAN_W  = 12;

   localparam logic [EXP_W-1:0]  EXP_INF   = 5'd31;
   localparam logic [FP16_W-1:0] FP16_INF  = 16'h7C00;
   localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      OP    = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Magnitude order is exponent first, then fraction, which is plain
   // unsigned order on the low 15 bits.
   function automatic logic mag_ge(input logic [FP16_W-2:0] a, input logic [FP16_W-2:0] b);
      return (a >= b);
   endfunction

endpackage

// File: rtl/fp16_classify.sv
// Splits one FP16 word into the fields the subtractor works on.
// Exponent 0 is zero (no denormals), exponent 31 is overflow.
module fp16_classify
   import fp16_pkg::*;
(
   input  logic [FP16_W-1:0] word,
   output logic              is_zero,
   output logic              is_inf,
   output logic              sign,
   output logic [EXP_W-1:0]  exp,
   output logic [MAN_W-1:0]  man12
);

   assign exp     = word[FP16_W-2:FRAC_W];
   assign sign    = word[FP16_W-1];
   assign is_zero = (exp == 5'd0);
   assign is_inf  = (exp == EXP_INF);
   // One guard bit above the hidden 1 catches the carry of an addition.
   assign man12   = {1'b0, 1'b1, word[FRAC_W-1:0]};

endmodule

// File: rtl/fp16_sub_seq.sv
// Multi-cycle FP16 subtractor (A - B): one alignment or normalisation
// bit per cycle behind a valid/ready handshake, one operation in flight.
module fp16_sub_seq
   import fp16_pkg::*;
#(
   parameter int MAX_ALIGN = 12
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [FP16_W-1:0] opA_i,
   input  logic [FP16_W-1:0] opB_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [FP16_W-1:0] SUB_o
);

   localparam logic [EXP_W-1:0] MAX_ALIGN_E = EXP_W'(MAX_ALIGN);

   logic              a_zero_s, a_inf_s, a_sign_s;
   logic              b_zero_s, b_inf_s, b_sign_s;
   logic [EXP_W-1:0]  a_exp_s, b_exp_s, diff_s;
   logic [MAN_W-1:0]  a_man_s, b_man_s;
   logic              a_ge_b_s;

   state_t            state_r, state_s;
   logic [EXP_W:0]    exp_r, exp_s;
   logic              sign_r, sign_s;
   logic              add_r, add_s;
   logic [EXP_W-1:0]  cnt_r, cnt_s;
   logic [MAN_W-1:0]  x_man_r, x_man_s, y_man_r, y_man_s, man_r, man_s;
   logic [FP16_W-1:0] result_r, result_s;
   logic              out_valid_r, out_valid_s;
   logic              in_ready_r;

   fp16_classify u_cls_a (
      .word(opA_i), .is_zero(a_zero_s), .is_inf(a_inf_s),
      .sign(a_sign_s), .exp(a_exp_s), .man12(a_man_s)
   );

   fp16_classify u_cls_b (
      .word(opB_i), .is_zero(b_zero_s), .is_inf(b_inf_s),
      .sign(b_sign_s), .exp(b_exp_s), .man12(b_man_s)
   );

   assign a_ge_b_s = mag_ge(opA_i[FP16_W-2:0], opB_i[FP16_W-2:0]);
   assign diff_s   = a_ge_b_s ? (a_exp_s - b_exp_s) : (b_exp_s - a_exp_s);

   // Next-state and datapath update for every FSM state.
   always_comb begin
      state_s     = state_r;
      exp_s       = exp_r;
      sign_s      = sign_r;
      add_s       = add_r;
      cnt_s       = cnt_r;
      x_man_s     = x_man_r;
      y_man_s     = y_man_r;
      man_s       = man_r;
      result_s    = result_r;
      out_valid_s = out_valid_r;
      case (state_r)
         IDLE: begin
            if (!in_valid_i) begin
               state_s = IDLE;
            end else if (a_inf_s || b_inf_s) begin
               result_s    = FP16_INF;
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else if (a_zero_s) begin
               result_s    = b_zero_s ? FP16_ZERO : {~b_sign_s, opB_i[FP16_W-2:0]};
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else if (b_zero_s) begin
               result_s    = opA_i;
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else begin
               // B enters with its sign flipped; X keeps the larger magnitude.
               add_s   = a_sign_s ^ b_sign_s;
               cnt_s   = (diff_s > MAX_ALIGN_E) ? MAX_ALIGN_E : diff_s;
               state_s = ALIGN;
               if (a_ge_b_s) begin
                  exp_s   = {1'b0, a_exp_s};
                  sign_s  = a_sign_s;
                  x_man_s = a_man_s;
                  y_man_s = b_man_s;
               end else begin
                  exp_s   = {1'b0, b_exp_s};
                  sign_s  = ~b_sign_s;
                  x_man_s = b_man_s;
                  y_man_s = a_man_s;
               end
            end
         end
         ALIGN: begin
            if (cnt_r == 5'd0) begin
               state_s = OP;
            end else begin
               y_man_s = y_man_r >> 1;
               cnt_s   = cnt_r - 5'd1;
            end
         end
         OP: begin
            man_s   = add_r ? (x_man_r + y_man_r) : (x_man_r - y_man_r);
            state_s = NORM;
         end
         NORM: begin
            if (man_r == 12'd0) begin
               result_s    = FP16_ZERO;
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else if (man_r[MAN_W-1]) begin
               man_s = man_r >> 1;
               exp_s = exp_r + 6'd1;
            end else if (man_r[FRAC_W]) begin
               if (exp_r >= 6'd31) begin
                  result_s = {sign_r, 5'h1F, 10'h000};
               end else begin
                  result_s = {sign_r, exp_r[EXP_W-1:0], man_r[FRAC_W-1:0]};
               end
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else if (exp_r <= 6'd1) begin
               result_s    = FP16_ZERO;
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else begin
               man_s = man_r << 1;
               exp_s = exp_r - 6'd1;
            end
         end
         DONE: begin
            if (out_ready_i) begin
               out_valid_s = 1'b0;
               state_s     = IDLE;
            end else begin
               out_valid_s = 1'b1;
            end
         end
         default: begin
            out_valid_s = 1'b0;
            state_s     = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         exp_r       <= 6'd0;
         sign_r      <= 1'b0;
         add_r       <= 1'b0;
         cnt_r       <= 5'd0;
         x_man_r     <= 12'd0;
         y_man_r     <= 12'd0;
         man_r       <= 12'd0;
         result_r    <= FP16_ZERO;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_s;
         exp_r       <= exp_s;
         sign_r      <= sign_s;
         add_r       <= add_s;
         cnt_r       <= cnt_s;
         x_man_r     <= x_man_s;
         y_man_r     <= y_man_s;
         man_r       <= man_s;
         result_r    <= result_s;
         out_valid_r <= out_valid_s;
         in_ready_r  <= (state_s == IDLE);
      end
   end

   assign in_ready_o  = in_ready_r;
   assign out_valid_o = out_valid_r;
   assign SUB_o       = result_r;

endmodule

// File: tb/tb_fp16_sub_seq.sv
// Directed, table-driven bench for fp16_sub_seq plus handshake and reset sequences.
// Latency is counted in clock edges after the accept edge until out_valid_o is seen.
module tb_fp16_sub_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sub;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] exp_sub;
      int          lat;
   } vec_t;

   vec_t vecs[13];

   fp16_sub_seq #(.MAX_ALIGN(12)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .opA_i(op_a), .opB_i(op_b),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .SUB_o(sub)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Accepts one operand pair; returns edges after accept until out_valid (40 on timeout).
   task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b, input string name,
                                 output int lat);
      @(negedge clk);
      chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      op_a = a;
      op_b = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic release_result(input string name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({name, ".release"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int stale;
      string nm;

      vecs[0]  = '{16'h3C00, 16'hBC00, 16'h4000, 4};   // 1 - (-1), carry renorm
      vecs[1]  = '{16'h4000, 16'h3C00, 16'h3C00, 5};   // 2 - 1: d=1, one left shift
      vecs[2]  = '{16'h3C00, 16'h3C00, 16'h0000, 3};   // exact cancellation
      vecs[3]  = '{16'h7BFF, 16'hFBFF, 16'h7C00, 4};   // carry into exp 31
      vecs[4]  = '{16'h7C00, 16'h3C00, 16'h7C00, 0};   // A overflow input
      vecs[5]  = '{16'h0000, 16'h3C00, 16'hBC00, 0};   // A zero
      vecs[6]  = '{16'h3C00, 16'h0000, 16'h3C00, 0};   // B zero
      vecs[7]  = '{16'h3C00, 16'h3800, 16'h3800, 5};   // 1 - 0.5
      vecs[8]  = '{16'h3C00, 16'h4000, 16'hBC00, 5};   // B larger: negative result
      vecs[9]  = '{16'h7000, 16'h3C00, 16'h7000, 15};  // d=13 saturates at 12
      vecs[10] = '{16'h0401, 16'h0400, 16'h0000, 3};   // underflow flush at exp 1
      vecs[11] = '{16'hBC00, 16'h3C00, 16'hC000, 4};   // -1 - 1
      vecs[12] = '{16'h3C00, 16'hFC00, 16'h7C00, 0};   // B overflow input

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op_a = 16'h0000;
      op_b = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset.sub", {16'd0, sub}, 32'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         nm = $sformatf("vec%0d", i);
         start_and_wait(vecs[i].a, vecs[i].b, nm, lat);
         chk({nm, ".latency"}, lat, vecs[i].lat);
         chk({nm, ".sub"}, {16'd0, sub}, {16'd0, vecs[i].exp_sub});
         release_result(nm);
      end

      // Backpressure: result held, new operands ignored while out_ready is low.
      start_and_wait(16'h3C00, 16'hBC00, "bp", lat);
      chk("bp.latency", lat, 4);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b1;
         op_a = 16'h4000;
         op_b = 16'h3C00;
         @(posedge clk);
         #1;
         chk("bp.hold", {15'd0, out_valid, in_ready, sub}, {15'd0, 1'b1, 1'b0, 16'h4000});
      end
      @(negedge clk);
      in_valid = 1'b0;
      release_result("bp");

      // Reset during ALIGN aborts the operation.
      start_and_wait(16'h6000, 16'h3C00, "rst", lat);
      release_result("rst_pre");
      @(negedge clk);
      op_a = 16'h6000;
      op_b = 16'h3C00;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst.sub", {16'd0, sub}, 32'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      chk("midrst.no_stale", stale, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
